mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles waiting for bus_ack before error.
REQ-003 The clock is clk, a single clock; reset is rst_n, asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  pipeline access request
- req_ready  out  1  unit can accept request
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_offset  in  2  size: 01 byte, 10 half, 11 word, 00 none
- unsigned_flag  in  1  zero-extend load
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load data
- rsp_err  out  1  error qualifier on rsp_valid
- stall  out  1  pipeline hold
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word-aligned address
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-positioned store data
- bus_ack  in  1  bus completion
- bus_rdata  in  32  bus read word

Function
REQ-005 The FSM SHALL have states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-006 Accept SHALL occur on req_valid&&req_ready; addr, wdata, size, flags latched that edge.
REQ-007 Accepted request with mem_offset==00, or mem_read==mem_write, SHALL go to RESP with rsp_err=1, no bus activity.
REQ-008 Valid request SHALL enter BUS next cycle; bus_req held 1 and bus signals stable until bus_ack sampled 1.
REQ-009 bus_addr = {addr[ADDR_W-1:2],2'b00}; bus_we = mem_write.
REQ-010 bus_be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-011 bus_wdata: byte replicated 4x, half replicated 2x, word unchanged.
REQ-012 Load: lane selected by addr[1:0] (byte) or addr[1] (half); sign-extended unless unsigned_flag; word unmodified.
REQ-013 bus_ack in BUS SHALL move to RESP; rsp_valid=1 for exactly one cycle in RESP, then IDLE; minimum latency accept-to-rsp_valid = 2 cycles with same-cycle ack.
REQ-014 Cycle counter SHALL count BUS cycles; reaching TIMEOUT without ack drops bus_req, enters RESP with rsp_err=1.
REQ-015 rdata SHALL be 0 for stores and errors.
REQ-016 stall = req_valid && !(rsp_valid from that request); i.e. high in IDLE-accept cycle, BUS, low in RESP.
REQ-017 bus_ack outside BUS SHALL be ignored.

Reset
REQ-018 rst_n low SHALL force IDLE, counter 0, and all outputs 0 except req_ready=1, asynchronously, including mid-transaction; the aborted access produces no response.

Configuration
REQ-019 Macro MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go to RESP with rsp_err=1, no bus activity.
REQ-020 Macro undefined: misaligned low address bits SHALL be cleared (half addr[0], word addr[1:0]) and access proceeds normally.

Structure
REQ-021 Shared package SHALL hold size encodings (SZ_NONE/BYTE/HALF/WORD) and FSM state typedef.
REQ-022 Sub-module mem_lane_align SHALL implement byte-enable generation, store replication and load extraction/extension combinationally.

Verification
REQ-023 lb addr=0x1003, bus_rdata=0x80FF_FFFF -> bus_be=1000, rdata=0xFFFF_FF80, rsp_err=0.
REQ-024 lhu addr=0x1002, bus_rdata=0x8001_1234 -> bus_be=1100, rdata=0x0000_8001.
REQ-025 sb addr=0x2001, wdata=0x0000_00AB -> bus_be=0010, bus_wdata=0xABAB_ABAB, bus_we=1.
REQ-026 lw addr=0x3000, bus_ack never asserted -> rsp_valid with rsp_err=1 after 255 BUS cycles.
REQ-027 sw addr=0x4002 -> rsp_err=1 no bus_req (macro defined); bus_addr=0x4000, be=1111 (undefined).
REQ-028 rst_n low during BUS -> bus_req=0 immediately, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the load/store access unit:
//   size_e  - access size encoding as carried on mem_offset
//   state_e - access FSM states
//   align_lo() - forces natural alignment of the low address bits
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } state_e;

   // Clear the address bits below the natural alignment of the access size.
   function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] lo);
      logic [1:0] res;
      res = lo;
      if (sz == SZ_HALF) res[0] = 1'b0;
      if (sz == SZ_WORD) res    = 2'b00;
      return res;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational lane steering between the LSB-aligned pipeline view and the
// 32-bit word-addressed bus view.
// Ports:
//   i_size      access size (byte/half/word)
//   i_addr_lo   byte address bits [1:0]
//   i_unsigned  zero-extend loads instead of sign-extending
//   i_wdata     LSB-aligned store data
//   i_bus_rdata bus read word
//   o_be        byte enables for the access
//   o_wdata     store data replicated across all lanes
//   o_rdata     extracted and extended load data
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  size_e       i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_bus_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Move the addressed byte lane down to bit 0.
   assign w_shift = i_bus_rdata >> {i_addr_lo, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = i_wdata;
      o_rdata = 32'h0;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_bus_rdata;
         end
         default: begin
            o_be    = 4'b0000;
            o_wdata = i_wdata;
            o_rdata = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Single-outstanding load/store unit bridging a pipeline request port to a
// word-addressed bus with byte enables, with ack timeout.
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses complete with rsp_err, no bus
//   undefined - misaligned low address bits are cleared and access proceeds
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   mem_read, mem_write          access direction (exactly one must be set)
//   mem_offset, unsigned_flag    access size, load zero-extension
//   addr, wdata                  byte address, LSB-aligned store data
//   rsp_valid, rdata, rsp_err    one-cycle completion with load data / error
//   stall                        pipeline hold while access is in flight
//   bus_req/we/addr/be/wdata     bus request side, stable while bus_req=1
//   bus_ack, bus_rdata           bus completion and read word
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_offset,
   input  logic              unsigned_flag,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              rsp_valid,
   output logic [31:0]       rdata,
   output logic              rsp_err,
   output logic              stall,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [31:0]       r_rdata;

   logic [ADDR_W-1:0] r_addr;
   size_e             r_size;
   logic              r_we;
   logic              r_uns;
   logic [31:0]       r_wdata;

   logic              w_accept;
   size_e             w_size;
   logic              w_bad_cmd;
   logic              w_trap;
   logic [1:0]        w_addr_lo;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_load;

   assign w_accept  = req_valid && (r_state == IDLE);
   assign w_size    = size_e'(mem_offset);
   assign w_bad_cmd = (w_size == SZ_NONE) || (mem_read == mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap    = ((w_size == SZ_HALF) && addr[0]) ||
                      ((w_size == SZ_WORD) && (addr[1:0] != 2'b00));
   assign w_addr_lo = addr[1:0];
`else
   assign w_trap    = 1'b0;
   assign w_addr_lo = align_lo(w_size, addr[1:0]);
`endif

   // Request payload: only meaningful while a bus access is in flight, and
   // all bus outputs are gated by bus_req, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= {addr[ADDR_W-1:2], w_addr_lo};
         r_size  <= w_size;
         r_we    <= mem_write;
         r_uns   <= unsigned_flag;
         r_wdata <= wdata;
      end
   end

   mem_lane_align u_lane (
      .i_size      (r_size),
      .i_addr_lo   (r_addr[1:0]),
      .i_unsigned  (r_uns),
      .i_wdata     (r_wdata),
      .i_bus_rdata (bus_rdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_rdata     (w_load)
   );

   // Access FSM; response outputs are registered on the transition into RESP
   // so they are valid for exactly the one RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rdata     <= 32'h0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rdata     <= 32'h0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  if (w_bad_cmd || w_trap) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state <= BUS;
                  end
               end
            end
            BUS: begin
               if (bus_ack) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rdata     <= r_we ? 32'h0 : w_load;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // TIMEOUT-th bus cycle without ack: give up.
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign bus_req   = (r_state == BUS);
   assign bus_we    = bus_req && r_we;
   assign bus_addr  = bus_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign bus_be    = bus_req ? w_be : 4'b0000;
   assign bus_wdata = (bus_req && r_we) ? w_wdata : 32'h0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rdata     = r_rdata;
   // Hold the pipeline from the accept cycle until the response cycle.
   assign stall     = (r_state == BUS) || ((r_state == IDLE) && req_valid);

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed scoreboard bench: stimulus pushes expected bus transactions and
// responses; a bus responder and a response monitor pop and compare them.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_offset;
   logic        unsigned_flag;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        rsp_err;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_offset    (mem_offset),
      .unsigned_flag (unsigned_flag),
      .addr          (addr),
      .wdata         (wdata),
      .rsp_valid     (rsp_valid),
      .rdata         (rdata),
      .rsp_err       (rsp_err),
      .stall         (stall),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_be        (bus_be),
      .bus_wdata     (bus_wdata),
      .bus_ack       (bus_ack),
      .bus_rdata     (bus_rdata)
   );

   // delay >= 0: ack after that many extra BUS cycles
   // delay == -1: never ack, expect timeout after 255 BUS cycles
   // delay == -2: never ack, transaction is aborted by reset
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rd;
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int t_acc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int dly, input logic [31:0] rd);
      bus_t b;
      b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.delay = dly; b.rd = rd;
      bus_q.push_back(b);
   endtask

   task automatic exp_rsp(input logic [31:0] rd, input logic err, input int lat);
      rsp_t r;
      r.rdata = rd; r.err = err; r.lat = lat;
      rsp_q.push_back(r);
   endtask

   // Bus responder / bus-side checker
   initial begin
      bus_t b;
      int   n;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (rst_n && bus_req) begin
            if (bus_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_bus_req: got bus_req=1 addr=0x%08h expected no bus access", bus_addr);
               while (bus_req) @(negedge clk);
            end else begin
               b = bus_q.pop_front();
               check("bus_we",   32'(bus_we), 32'(b.we));
               check("bus_addr", bus_addr,    b.addr);
               check("bus_be",   32'(bus_be), 32'(b.be));
               if (b.we) check("bus_wdata", bus_wdata, b.wdata);
               check("stall_bus", 32'(stall), 32'd1);
               if (b.delay < 0) begin
                  n = 0;
                  while (bus_req && n < 1000) begin
                     n++;
                     @(negedge clk);
                  end
                  if (b.delay == -1) check("timeout_cycles", 32'(n), 32'd255);
               end else begin
                  for (int i = 0; i < b.delay; i++) begin
                     @(negedge clk);
                     check("bus_be_hold", 32'(bus_be), 32'(b.be));
                  end
                  bus_ack   = 1'b1;
                  bus_rdata = b.rd;
                  @(negedge clk);
                  bus_ack   = 1'b0;
                  bus_rdata = 32'h0;
               end
            end
         end
      end
   end

   // Response monitor
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h expected no response", rdata);
            end else begin
               r = rsp_q.pop_front();
               check("rdata",      rdata,         r.rdata);
               check("rsp_err",    32'(rsp_err),  32'(r.err));
               check("stall_resp", 32'(stall),    32'd0);
               if (r.lat > 0) check("latency", 32'(cyc - t_acc), 32'(r.lat));
            end
         end
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic [1:0] off,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 2000 cycles");
         $fatal(1);
      end
      req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_offset = off;
      unsigned_flag = uns; addr = a; wdata = wd;
      t_acc = cyc;
      #1 check("stall_accept", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0 || !req_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(rsp_q.size() + bus_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_offset = 2'b00; unsigned_flag = 1'b0; addr = 32'h0; wdata = 32'h0;
      #3;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_bus_req",   32'(bus_req),   32'd0);
      check("rst_stall",     32'(stall),     32'd0);
      check("rst_rdata",     rdata,          32'h0);
      check("rst_bus_be",    32'(bus_be),    32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // lb sign-extended, upper byte, same-cycle ack
      exp_bus(1'b0, 32'h1000, 4'b1000, 32'h0, 0, 32'h80FF_FFFF);
      exp_rsp(32'hFFFF_FF80, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h1003, 32'h0); wait_done();

      // lhu upper half
      exp_bus(1'b0, 32'h1000, 4'b1100, 32'h0, 2, 32'h8001_1234);
      exp_rsp(32'h0000_8001, 1'b0, 4);
      issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h1002, 32'h0); wait_done();

      // lh signed upper half, lh lower half
      exp_bus(1'b0, 32'h1000, 4'b1100, 32'h0, 0, 32'h8001_1234);
      exp_rsp(32'hFFFF_8001, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0); wait_done();
      exp_bus(1'b0, 32'h1000, 4'b0011, 32'h0, 1, 32'h8001_9234);
      exp_rsp(32'hFFFF_9234, 1'b0, 3);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0); wait_done();

      // lbu lane 1
      exp_bus(1'b0, 32'h1000, 4'b0010, 32'h0, 0, 32'h0000_8000);
      exp_rsp(32'h0000_0080, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001, 32'h0); wait_done();

      // lw unchanged
      exp_bus(1'b0, 32'h2004, 4'b1111, 32'h0, 0, 32'h8765_4321);
      exp_rsp(32'h8765_4321, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h2004, 32'h0); wait_done();

      // sb / sh / sw
      exp_bus(1'b1, 32'h2000, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
      exp_rsp(32'h0, 1'b0, 2);
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h2001, 32'h1234_56AB); wait_done();
      exp_bus(1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1, 32'hFFFF_FFFF);
      exp_rsp(32'h0, 1'b0, 3);
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h2002, 32'hDEAD_BEEF); wait_done();
      exp_bus(1'b1, 32'h2000, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
      exp_rsp(32'h0, 1'b0, 2);
      issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h2000, 32'hCAFE_F00D); wait_done();

      // illegal commands: size none, read+write, neither
      exp_rsp(32'h0, 1'b1, 1);
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0); wait_done();
      exp_rsp(32'h0, 1'b1, 1);
      issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h1000, 32'h0); wait_done();
      exp_rsp(32'h0, 1'b1, 1);
      issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0); wait_done();

      // lw with no ack: timeout
      exp_bus(1'b0, 32'h3000, 4'b1111, 32'h0, -1, 32'h0);
      exp_rsp(32'h0, 1'b1, 256);
      issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h3000, 32'h0); wait_done();

      // misaligned sw and lh
`ifdef MEM_MISALIGN_TRAP_EN
      exp_rsp(32'h0, 1'b1, 1);
      issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h4002, 32'h1122_3344); wait_done();
      exp_rsp(32'h0, 1'b1, 1);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001, 32'h0); wait_done();
`else
      exp_bus(1'b1, 32'h4000, 4'b1111, 32'h1122_3344, 0, 32'h0);
      exp_rsp(32'h0, 1'b0, 2);
      issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h4002, 32'h1122_3344); wait_done();
      exp_bus(1'b0, 32'h1000, 4'b0011, 32'h0, 0, 32'h0000_7F00);
      exp_rsp(32'h0000_7F00, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001, 32'h0); wait_done();
`endif

      // reset during BUS: aborted, no response
      exp_bus(1'b0, 32'h5000, 4'b1111, 32'h0, -2, 32'h0);
      issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h5000, 32'h0);
      n = 0;
      while (!bus_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_bus_req",   32'(bus_req),   32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_stall",     32'(stall),     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_no_rsp_q", 32'(rsp_q.size()), 32'd0);

      // unit usable after abort
      exp_bus(1'b0, 32'h1000, 4'b0001, 32'h0, 0, 32'h0000_007F);
      exp_rsp(32'h0000_007F, 1'b0, 2);
      issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0); wait_done();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
